udma_hyper_tx_unpacker: RTL and testbench

- Sits between the 32-bit uDMA TX FIFO output and the HyperBus PHY write-data path.
- Consumes a byte stream delivered as 32-bit little-endian words and emits 16-bit DDR data beats with per-lane RWDS write masks.
- Handles odd start byte offset and odd transfer length, discards surplus bytes in the final input word, and flags the last beat.
- One transfer at a time, armed by a start pulse from the HyperBus transaction controller.

---
 rtl/udma_hyper_pkg.sv | 19 +
 rtl/udma_hyper_tx_unpacker_if.sv | 25 ++
 rtl/hyper_byte_realign.sv | 55 +++++
 rtl/udma_hyper_tx_unpacker.sv | 132 +++++++++++++
 tb/tb_udma_hyper_tx_unpacker.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/udma_hyper_pkg.sv
// Shared types and constants for the HyperBus TX unpacker.
package udma_hyper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hyper_txu_state_e;

  // Lane write masks: bit i set means lane i is not written.
  localparam logic [1:0] MASK_NONE = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;

  // Byte buffer depth and the width of its occupancy count.
  localparam int unsigned BUF_BYTES = 6;
  localparam int unsigned CNT_W     = 3;

endpackage

// File: rtl/udma_hyper_tx_unpacker_if.sv
// Word input stream and DDR beat output stream of the TX unpacker.
interface udma_hyper_tx_unpacker_if;

  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] phy_data_o;
  logic [1:0]  phy_mask_o;
  logic        phy_last_o;
  logic        phy_valid_o;
  logic        phy_ready_i;

  // Unpacker side.
  modport master (
    input  in_data_i, in_valid_i, phy_ready_i,
    output in_ready_o, phy_data_o, phy_mask_o, phy_last_o, phy_valid_o
  );

  // FIFO / PHY side.
  modport slave (
    output in_data_i, in_valid_i, phy_ready_i,
    input  in_ready_o, phy_data_o, phy_mask_o, phy_last_o, phy_valid_o
  );

endinterface

// File: rtl/hyper_byte_realign.sv
// Byte buffer: pushes 4 bytes at the tail, pops 1 or 2 bytes from the head.
// A clear may preload one zero byte so an odd start offset lines the stream
// up with lane 1 of the first beat.
module hyper_byte_realign
  import udma_hyper_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             preload_i,
  input  logic             push_i,
  input  logic [31:0]      push_data_i,
  input  logic             pop_i,
  input  logic             pop2_i,
  output logic [15:0]      head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [8*BUF_BYTES-1:0] buf_q, buf_d, shifted, wr_data, wr_mask;
  logic [CNT_W-1:0]       count_q, count_d, pop_n, base;

  // Drain the head first, then append the new word behind what is left.
  always_comb begin
    pop_n   = pop_i ? (pop2_i ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
    base    = count_q - pop_n;
    shifted = buf_q >> {pop_n, 3'b000};
    wr_data = {{(8*BUF_BYTES-32){1'b0}}, push_data_i} << {base, 3'b000};
    wr_mask = {{(8*BUF_BYTES-32){1'b0}}, 32'hFFFF_FFFF} << {base, 3'b000};
    buf_d   = shifted;
    count_d = base;
    if (push_i) begin
      buf_d   = (shifted & ~wr_mask) | wr_data;
      count_d = base + CNT_W'(4);
    end
    if (clr_i) begin
      buf_d   = '0;
      count_d = {{(CNT_W-1){1'b0}}, preload_i};
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign head_o  = buf_q[15:0];
  assign count_o = count_q;

endmodule

// File: rtl/udma_hyper_tx_unpacker.sv
// Unpacks 32-bit little-endian TX words into 16-bit HyperBus DDR beats
// with per-lane write masks.
//
//   state   | meaning
//   IDLE    | waiting for trans_start_i
//   RUN     | accepting words, emitting beats
//   DONE    | transfer finished; done_o pulses, then back to IDLE
module udma_hyper_tx_unpacker
  import udma_hyper_pkg::*;
#(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trans_start_i,
  input  logic [TRANS_SIZE-1:0] trans_len_i,
  input  logic                  trans_offset_i,
  input  logic                  abort_i,
  udma_hyper_tx_unpacker_if.master bus,
  output logic                  busy_o,
  output logic                  done_o
);

  hyper_txu_state_e      state_q;
  logic [TRANS_SIZE-1:0] beats_rem_q, beats_init;
  logic [TRANS_SIZE-2:0] words_rem_q, words_init;
  logic                  first_q, off_q, odd_end_q, busy_q, done_q;

  logic [15:0]      head;
  logic [CNT_W-1:0] count, drain;
  logic             last_beat, need2, beat_ok, pop, push, in_ready, start_go;
  logic [1:0]       lane_mask;

  // Beat count ceil((off+len)/2) and word count ceil(len/4), one bit wider
  // internally so len = 2^TRANS_SIZE-1 does not wrap.
  assign beats_init = TRANS_SIZE'(({1'b0, trans_len_i} + {{TRANS_SIZE{1'b0}}, trans_offset_i}
                                   + (TRANS_SIZE+1)'(1)) >> 1);
  assign words_init = (TRANS_SIZE-1)'(({1'b0, trans_len_i} + (TRANS_SIZE+1)'(3)) >> 2);

  assign start_go  = (state_q == ST_IDLE) && trans_start_i && !abort_i;
  assign last_beat = (beats_rem_q == TRANS_SIZE'(1));
  // A final beat whose upper lane is masked needs only one buffered byte.
  assign need2     = !(last_beat && odd_end_q);
  assign beat_ok   = (state_q == ST_RUN) && (need2 ? (count >= CNT_W'(2)) : (count != '0));
  assign pop       = beat_ok && bus.phy_ready_i;
  assign drain     = pop ? (need2 ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
  assign in_ready  = (state_q == ST_RUN) && (words_rem_q != '0)
                     && ((count - drain) <= CNT_W'(BUF_BYTES - 4));
  assign push      = bus.in_valid_i && in_ready;
  assign lane_mask = (last_beat && odd_end_q ? MASK_HI : MASK_NONE)
                   | (first_q && off_q ? MASK_LO : MASK_NONE);

  hyper_byte_realign u_realign (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (abort_i || start_go),
    .preload_i   (trans_offset_i && !abort_i),
    .push_i      (push),
    .push_data_i (bus.in_data_i),
    .pop_i       (pop),
    .pop2_i      (need2),
    .head_o      (head),
    .count_o     (count)
  );

  // Transfer sequencing, beat/word counters and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      beats_rem_q <= '0;
      words_rem_q <= '0;
      first_q     <= 1'b0;
      off_q       <= 1'b0;
      odd_end_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (trans_start_i) begin
            beats_rem_q <= beats_init;
            words_rem_q <= words_init;
            first_q     <= 1'b1;
            off_q       <= trans_offset_i;
            odd_end_q   <= trans_len_i[0] ^ trans_offset_i;
            busy_q      <= 1'b1;
            state_q     <= (trans_len_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (push) words_rem_q <= words_rem_q - 1'b1;
          if (pop) begin
            beats_rem_q <= beats_rem_q - 1'b1;
            first_q     <= 1'b0;
            if (last_beat) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Entered with done_q=0 only for a zero-length transfer, which
          // spends one busy cycle here before pulsing done_o.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.phy_valid_o = beat_ok;
  assign bus.phy_mask_o  = beat_ok ? lane_mask : MASK_NONE;
  assign bus.phy_last_o  = beat_ok && last_beat;
  assign bus.phy_data_o  = beat_ok ? {lane_mask[1] ? 8'h00 : head[15:8],
                                      lane_mask[0] ? 8'h00 : head[7:0]} : 16'h0000;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_udma_hyper_tx_unpacker.sv
// Directed bench for the HyperBus TX unpacker.
module tb_udma_hyper_tx_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_start;
  logic [15:0] trans_len;
  logic        trans_off;
  logic        abort;
  logic        busy, done;

  udma_hyper_tx_unpacker_if ifc ();

  udma_hyper_tx_unpacker #(.TRANS_SIZE(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .trans_start_i  (trans_start),
    .trans_len_i    (trans_len),
    .trans_offset_i (trans_off),
    .abort_i        (abort),
    .bus            (ifc.master),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [18:0] beat_q[$];
  int          beat_it[$];
  logic [18:0] exp_q[$];
  logic [31:0] wq[$];
  int          words_taken, first_in_it, done_it, done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] snap();
    return {ifc.phy_last_o, ifc.phy_mask_o, ifc.phy_data_o};
  endfunction

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < beat_q.size()) chk($sformatf("%s_beat%0d", tag, i), beat_q[i], exp_q[i]);
  endtask

  // Starts a transfer and runs it cycle by cycle; abort_after >= 0 aborts
  // once that many beats have been handed over.
  task automatic run_xfer(input int len, input bit off, input bit tog, input bit gaps,
                          input int abort_after);
    int          it, widx;
    bit          finished, stalled;
    logic [18:0] prev;
    beat_q.delete(); beat_it.delete();
    words_taken = 0; first_in_it = -1; done_it = -1; done_cnt = 0;
    widx = 0; it = 0; finished = 0; stalled = 0; prev = '0;
    @(posedge clk); #1;
    trans_start = 1'b1; trans_len = 16'(len); trans_off = off;
    while (!finished && it < 200) begin
      it++;
      @(posedge clk); #1;
      trans_start = 1'b0;
      if (abort_after >= 0 && beat_q.size() == abort_after) begin
        abort = 1'b1; ifc.in_valid_i = 1'b0; ifc.phy_ready_i = 1'b0; finished = 1;
      end else begin
        ifc.in_valid_i  = (widx < wq.size()) && !(gaps && (it % 3 == 2));
        ifc.in_data_i   = (widx < wq.size()) ? wq[widx] : 32'hDEAD_BEEF;
        ifc.phy_ready_i = tog ? it[0] : 1'b1;
      end
      @(negedge clk);
      if (stalled) chk("stall_hold", {ifc.phy_valid_o, snap()}, {1'b1, prev});
      stalled = ifc.phy_valid_o && !ifc.phy_ready_i;
      prev    = snap();
      if (ifc.phy_valid_o && ifc.phy_ready_i) begin
        beat_q.push_back(snap()); beat_it.push_back(it);
      end
      if (ifc.in_valid_i && ifc.in_ready_o) begin
        if (first_in_it < 0) first_in_it = it;
        widx++; words_taken++;
      end
      if (done) begin
        done_cnt++;
        if (done_it < 0) done_it = it;
        finished = 1;
      end
    end
    ifc.in_valid_i = 1'b0; ifc.phy_ready_i = 1'b0;
    if (abort_after >= 0) begin
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
    end else begin
      chk("xfer_completed", 32'(done_it >= 0), 1);
    end
  endtask

  initial begin
    int done_acc;
    rst = 1'b1; trans_start = 1'b0; trans_len = '0; trans_off = 1'b0; abort = 1'b0;
    ifc.in_data_i = '0; ifc.in_valid_i = 1'b0; ifc.phy_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  ifc.in_ready_o,  0);
    chk("rst_phy_valid", ifc.phy_valid_o, 0);
    chk("rst_phy_out",   snap(),          0);
    chk("rst_busy_done", {busy, done},    0);
    @(posedge clk); #1 rst = 1'b0;

    // len 8, offset 0, full throughput
    wq = '{32'h0302_0100, 32'h0706_0504};
    run_xfer(8, 1'b0, 1'b0, 1'b0, -1);
    exp_q = '{19'h00100, 19'h00302, 19'h00504, 19'h40706};
    chk_beats("t1");
    chk("t1_words",     words_taken, 2);
    chk("t1_latency",   beat_it[0] - first_in_it, 1);
    chk("t1_back2back", beat_it[3] - beat_it[0], 3);
    chk("t1_done_at",   done_it - beat_it[3], 1);
    @(negedge clk);
    chk("t1_done_pulse", {busy, done}, 0);

    // len 3, offset 1: masked first lane, surplus byte dropped
    wq = '{32'hDDCC_BBAA};
    run_xfer(3, 1'b1, 1'b0, 1'b0, -1);
    exp_q = '{19'h1AA00, 19'h4CCBB};
    chk_beats("t2");
    chk("t2_words", words_taken, 1);

    // len 5, offset 0: masked last upper lane
    wq = '{32'h0302_0100, 32'h0706_0504};
    run_xfer(5, 1'b0, 1'b0, 1'b0, -1);
    exp_q = '{19'h00100, 19'h00302, 19'h60004};
    chk_beats("t3");
    chk("t3_words", words_taken, 2);

    // len 16, offset 1, PHY stalls and input gaps
    wq = '{32'h1312_1110, 32'h1716_1514, 32'h1B1A_1918, 32'h1F1E_1D1C};
    run_xfer(16, 1'b1, 1'b1, 1'b1, -1);
    exp_q = '{19'h11000, 19'h01211, 19'h01413, 19'h01615, 19'h01817,
              19'h01A19, 19'h01C1B, 19'h01E1D, 19'h6001F};
    chk_beats("t4");
    chk("t4_words", words_taken, 4);

    // zero-length transfer, second start while busy
    @(posedge clk); #1;
    trans_start = 1'b1; trans_len = 16'd0; trans_off = 1'b0;
    @(posedge clk); #1;
    trans_len = 16'd4; trans_off = 1'b1;
    @(negedge clk);
    chk("t5_busy_cycle", {busy, done, ifc.in_ready_o}, 3'b100);
    @(posedge clk); #1 trans_start = 1'b0;
    @(negedge clk);
    chk("t5_done_cycle", {busy, done, ifc.in_ready_o, ifc.phy_valid_o}, 4'b0100);
    @(negedge clk);
    chk("t5_after", {busy, done, ifc.in_ready_o, ifc.phy_valid_o}, 4'b0000);
    @(negedge clk);
    chk("t5_restart_ignored", {busy, ifc.in_ready_o}, 2'b00);

    // abort after 2 of 4 beats, then a clean new transfer
    wq = '{32'h0302_0100, 32'h0706_0504};
    run_xfer(8, 1'b0, 1'b0, 1'b0, 2);
    chk("t6_beats_pre_abort", beat_q.size(), 2);
    chk("t6_abort_state", {busy, done, ifc.in_ready_o, ifc.phy_valid_o}, 4'b0000);
    chk("t6_abort_out", snap(), 0);
    done_acc = 0;
    repeat (3) begin
      @(negedge clk);
      done_acc += int'(done);
    end
    chk("t6_no_done", done_acc, 0);
    wq = '{32'h4433_2211};
    run_xfer(4, 1'b0, 1'b0, 1'b0, -1);
    exp_q = '{19'h02211, 19'h44433};
    chk_beats("t6");
    chk("t6_words", words_taken, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
